control_sequencer: RTL and testbench



---
 rtl/ctrl_pkg.sv | 68 ++++++
 rtl/control_sequencer_if.sv | 42 ++++
 rtl/control_rom.sv | 75 +++++++
 rtl/control_sequencer.sv | 127 ++++++++++++
 tb/tb_control_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the 4-bit computer control sequencer: ISA opcodes,
// ALU operation codes, sequencer state encodings and the control word.
package ctrl_pkg;

    localparam int OPW = 4;
    localparam int AW  = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'h0;
    localparam logic [OPW-1:0] OP_LDA = 4'h1;
    localparam logic [OPW-1:0] OP_ADD = 4'h2;
    localparam logic [OPW-1:0] OP_SUB = 4'h3;
    localparam logic [OPW-1:0] OP_STA = 4'h4;
    localparam logic [OPW-1:0] OP_LDI = 4'h5;
    localparam logic [OPW-1:0] OP_JMP = 4'h6;
    localparam logic [OPW-1:0] OP_JZ  = 4'h7;
    localparam logic [OPW-1:0] OP_JC  = 4'h8;
    localparam logic [OPW-1:0] OP_OUT = 4'h9;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS_MEM = 2'b00;
    localparam logic [1:0] ALU_ADD      = 2'b01;
    localparam logic [1:0] ALU_SUB      = 2'b10;
    localparam logic [1:0] ALU_PASS_IMM = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_F_ADDR = 3'b001,
        S_F_INST = 3'b010,
        S_DECODE = 3'b011,
        S_EX1    = 3'b100,
        S_EX2    = 3'b101,
        S_EX3    = 3'b110,
        S_HALT   = 3'b111
    } state_t;

    typedef struct packed {
        logic       ir_we;
        logic       pc_inc;
        logic       pc_load;
        logic       pc_oe;
        logic       addr_oe;
        logic       mar_we;
        logic       ram_re;
        logic       ram_we;
        logic       acc_we;
        logic       acc_oe;
        logic       b_we;
        logic [1:0] alu_op;
        logic       flag_we;
        logic       out_we;
    } ctrl_word_t;

    // Opcodes 1..9 have at least one execute step; A..E fall back to NOP.
    function automatic logic has_exec(input logic [OPW-1:0] op);
        return (op >= OP_LDA) && (op <= OP_OUT);
    endfunction

    // Memory-operand instructions go through EX2 after addressing in EX1.
    function automatic logic needs_ex2(input logic [OPW-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
    endfunction

    // Arithmetic needs a third step to combine B with the accumulator.
    function automatic logic needs_ex3(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer and the datapath: IR/flag/run inputs toward
// the sequencer and every control strobe back toward the datapath.
interface control_sequencer_if;
    import ctrl_pkg::*;

    logic [OPW-1:0] INST;
    logic [AW-1:0]  ADDR;
    logic           RUN;
    logic           PRGM;
    logic           ZF;
    logic           CF;
    logic           IR_WE;
    logic           PC_INC;
    logic           PC_LOAD;
    logic           PC_OE;
    logic           ADDR_OE;
    logic           MAR_WE;
    logic           RAM_RE;
    logic           RAM_WE;
    logic           ACC_WE;
    logic           ACC_OE;
    logic           B_WE;
    logic [1:0]     ALU_OP;
    logic           FLAG_WE;
    logic           OUT_WE;
    logic           HALTED;
    logic           PRGM_ACK;
    logic [2:0]     STATE;

    modport master (
        input  INST, ADDR, RUN, PRGM, ZF, CF,
        output IR_WE, PC_INC, PC_LOAD, PC_OE, ADDR_OE, MAR_WE, RAM_RE, RAM_WE,
               ACC_WE, ACC_OE, B_WE, ALU_OP, FLAG_WE, OUT_WE, HALTED, PRGM_ACK, STATE
    );

    modport slave (
        output INST, ADDR, RUN, PRGM, ZF, CF,
        input  IR_WE, PC_INC, PC_LOAD, PC_OE, ADDR_OE, MAR_WE, RAM_RE, RAM_WE,
               ACC_WE, ACC_OE, B_WE, ALU_OP, FLAG_WE, OUT_WE, HALTED, PRGM_ACK, STATE
    );

endinterface

// File: rtl/control_rom.sv
// Pure combinational microcode: maps the current state, opcode and flags to
// the datapath control word. Idle, halt and program states yield all zeros.
module control_rom
    import ctrl_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] inst,
    input  logic           zf,
    input  logic           cf,
    output ctrl_word_t     cw
);

    // Decode the control word for the current microstep
    always_comb begin
        cw = '0;
        case (state)
            S_F_ADDR: begin
                cw.pc_oe  = 1'b1;
                cw.mar_we = 1'b1;
            end
            S_F_INST: begin
                cw.ram_re = 1'b1;
                cw.ir_we  = 1'b1;
                cw.pc_inc = 1'b1;
            end
            S_EX1: begin
                case (inst)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw.addr_oe = 1'b1;
                        cw.mar_we  = 1'b1;
                    end
                    OP_LDI: begin
                        cw.acc_we = 1'b1;
                        cw.alu_op = ALU_PASS_IMM;
                    end
                    OP_JMP: cw.pc_load = 1'b1;
                    OP_JZ:  cw.pc_load = zf;
                    OP_JC:  cw.pc_load = cf;
                    OP_OUT: begin
                        cw.acc_oe = 1'b1;
                        cw.out_we = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                case (inst)
                    OP_LDA: begin
                        cw.ram_re = 1'b1;
                        cw.acc_we = 1'b1;
                        cw.alu_op = ALU_PASS_MEM;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.ram_re = 1'b1;
                        cw.b_we   = 1'b1;
                    end
                    OP_STA: begin
                        cw.acc_oe = 1'b1;
                        cw.ram_we = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX3: begin
                if (needs_ex3(inst)) begin
                    cw.acc_we  = 1'b1;
                    cw.flag_we = 1'b1;
                    cw.alu_op  = (inst == OP_ADD) ? ALU_ADD : ALU_SUB;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit computer. Holds the state
// register and the PROGRAM flag; strobes come from control_rom.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    control_sequencer_if.master bus
);

    state_t     state;
    state_t     state_next;
    logic       prog;
    logic       prog_next;
    logic       boundary;
    ctrl_word_t cw;

    control_rom rom (
        .state (state),
        .inst  (bus.INST),
        .zf    (bus.ZF),
        .cf    (bus.CF),
        .cw    (cw)
    );

    // State register and PROGRAM flag; reset abandons any instruction in flight
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            prog  <= 1'b0;
        end else begin
            state <= state_next;
            prog  <= prog_next;
        end
    end

    // Next-state selection, with RUN/PRGM only consulted at instruction boundaries
    always_comb begin
        state_next = state;
        prog_next  = prog;
        boundary   = 1'b0;
        if (prog) begin
            // The state register parks in IDLE so every strobe stays low.
            state_next = S_IDLE;
            prog_next  = bus.PRGM;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.PRGM)
                        prog_next = 1'b1;
                    else if (bus.RUN)
                        state_next = S_F_ADDR;
                end
                S_F_ADDR: state_next = S_F_INST;
                S_F_INST: state_next = S_DECODE;
                S_DECODE: begin
                    if (bus.INST == OP_HLT)
                        state_next = S_HALT;
                    else if (has_exec(bus.INST))
                        state_next = S_EX1;
                    else
                        boundary = 1'b1;
                end
                S_EX1: begin
                    if (needs_ex2(bus.INST))
                        state_next = S_EX2;
                    else
                        boundary = 1'b1;
                end
                S_EX2: begin
                    if (needs_ex3(bus.INST))
                        state_next = S_EX3;
                    else
                        boundary = 1'b1;
                end
                S_EX3: boundary = 1'b1;
                S_HALT: begin
                    if (bus.PRGM) begin
                        prog_next  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
            if (boundary) begin
                if (bus.PRGM) begin
                    prog_next  = 1'b1;
                    state_next = S_IDLE;
                end else if (!bus.RUN) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_F_ADDR;
                end
            end
        end
    end

    // Drive the interface from the control word and the registered state
    always_comb begin
        bus.IR_WE    = cw.ir_we;
        bus.PC_INC   = cw.pc_inc;
        bus.PC_LOAD  = cw.pc_load;
        bus.PC_OE    = cw.pc_oe;
        bus.ADDR_OE  = cw.addr_oe;
        bus.MAR_WE   = cw.mar_we;
        bus.RAM_RE   = cw.ram_re;
        bus.RAM_WE   = cw.ram_we;
        bus.ACC_WE   = cw.acc_we;
        bus.ACC_OE   = cw.acc_oe;
        bus.B_WE     = cw.b_we;
        bus.ALU_OP   = cw.alu_op;
        bus.FLAG_WE  = cw.flag_we;
        bus.OUT_WE   = cw.out_we;
        bus.HALTED   = (state == S_HALT);
        bus.PRGM_ACK = prog;
        bus.STATE    = state;
    end

    // Bus drivers are mutually exclusive; the operand must be defined when driven
    always_ff @(posedge CLK) begin
        if (RESET_N) begin
            assert ($onehot0({cw.pc_oe, cw.addr_oe, cw.acc_oe, cw.ram_re}));
            assert (!(cw.addr_oe && $isunknown(bus.ADDR)));
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a small IR/PC model feeds INST/ADDR
// from a program image, and each cycle's strobes are compared to hand traces.
module tb_control_sequencer;

    logic CLK = 1'b0;
    logic RESET_N;

    control_sequencer_if bus();

    control_sequencer dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    logic [3:0] pc;
    bit         rand_mode;

    // Observation word bit weights
    localparam logic [16:0] W_IR   = 17'h10000;
    localparam logic [16:0] W_PCI  = 17'h08000;
    localparam logic [16:0] W_PCL  = 17'h04000;
    localparam logic [16:0] W_PCO  = 17'h02000;
    localparam logic [16:0] W_ADO  = 17'h01000;
    localparam logic [16:0] W_MAR  = 17'h00800;
    localparam logic [16:0] W_RRE  = 17'h00400;
    localparam logic [16:0] W_RWE  = 17'h00200;
    localparam logic [16:0] W_AWE  = 17'h00100;
    localparam logic [16:0] W_AOE  = 17'h00080;
    localparam logic [16:0] W_BWE  = 17'h00040;
    localparam logic [16:0] W_ALU1 = 17'h00020;
    localparam logic [16:0] W_ALU0 = 17'h00010;
    localparam logic [16:0] W_FWE  = 17'h00008;
    localparam logic [16:0] W_OWE  = 17'h00004;
    localparam logic [16:0] W_HLT  = 17'h00002;
    localparam logic [16:0] W_ACK  = 17'h00001;

    localparam logic [16:0] FA = W_PCO | W_MAR;
    localparam logic [16:0] FI = W_RRE | W_IR | W_PCI;
    localparam logic [16:0] EA = W_ADO | W_MAR;

    function automatic logic [16:0] word();
        return {bus.IR_WE, bus.PC_INC, bus.PC_LOAD, bus.PC_OE, bus.ADDR_OE, bus.MAR_WE,
                bus.RAM_RE, bus.RAM_WE, bus.ACC_WE, bus.ACC_OE, bus.B_WE, bus.ALU_OP,
                bus.FLAG_WE, bus.OUT_WE, bus.HALTED, bus.PRGM_ACK};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: capture pre-edge strobes, update the IR/PC model after the edge
    task automatic tick();
        logic ir, inc, ld;
        ir  = bus.IR_WE;
        inc = bus.PC_INC;
        ld  = bus.PC_LOAD;
        @(posedge CLK);
        #1;
        if (rand_mode) begin
            bus.INST = 4'($urandom_range(0, 15));
            bus.ADDR = 4'($urandom_range(0, 15));
            bus.ZF   = 1'($urandom_range(0, 1));
            bus.CF   = 1'($urandom_range(0, 1));
        end else begin
            if (ir) {bus.INST, bus.ADDR} = mem[pc];
            if (ld) pc = bus.ADDR;
            else if (inc) pc = pc + 4'd1;
        end
        #1;
    endtask

    task automatic step(input string tag, input logic [2:0] st, input logic [16:0] w);
        tick();
        chk(tag, {12'd0, bus.STATE, word()}, {12'd0, st, w});
    endtask

    initial begin
        RESET_N   = 1'b0;
        bus.RUN   = 1'b1;
        bus.PRGM  = 1'b0;
        bus.ZF    = 1'b0;
        bus.CF    = 1'b0;
        bus.INST  = 4'h0;
        bus.ADDR  = 4'h0;
        pc        = 4'h0;
        rand_mode = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset held two cycles with RUN=1, then release
        mem[0] = 8'h55; mem[1] = 8'h2E; mem[2] = 8'h90; mem[3] = 8'hF0;
        step("rst_c1", 3'd0, 17'h0);
        step("rst_c2", 3'd0, 17'h0);
        RESET_N = 1'b1;

        // LDI 5 (4 cycles)
        step("ldi_fa",  3'd1, FA);
        step("ldi_fi",  3'd2, FI);
        step("ldi_dec", 3'd3, 17'h0);
        chk("ldi_inst", {28'd0, bus.INST}, 32'h5);
        step("ldi_ex1", 3'd4, W_AWE | W_ALU1 | W_ALU0);
        // ADD 0xE (6 cycles)
        step("add_fa",  3'd1, FA);
        step("add_fi",  3'd2, FI);
        step("add_dec", 3'd3, 17'h0);
        step("add_ex1", 3'd4, EA);
        step("add_ex2", 3'd5, W_RRE | W_BWE);
        step("add_ex3", 3'd6, W_AWE | W_FWE | W_ALU0);
        // OUT (4 cycles)
        step("out_fa",  3'd1, FA);
        step("out_fi",  3'd2, FI);
        step("out_dec", 3'd3, 17'h0);
        step("out_ex1", 3'd4, W_AOE | W_OWE);
        // HLT (3 cycles) then stuck in HALT despite RUN
        step("hlt_fa",  3'd1, FA);
        step("hlt_fi",  3'd2, FI);
        step("hlt_dec", 3'd3, 17'h0);
        step("halt",    3'd7, W_HLT);
        bus.RUN = 1'b0;
        step("halt_run0", 3'd7, W_HLT);
        bus.RUN = 1'b1;
        step("halt_run1", 3'd7, W_HLT);

        // Conditional jumps, PRGM during ADD, reset during STA
        RESET_N = 1'b0;
        step("rst2", 3'd0, 17'h0);
        RESET_N = 1'b1;
        pc = 4'h0;
        mem[0] = 8'h73; mem[1] = 8'h74; mem[4] = 8'h86; mem[6] = 8'h21; mem[7] = 8'h4D;
        step("jz0_fa",  3'd1, FA);
        step("jz0_fi",  3'd2, FI);
        step("jz0_dec", 3'd3, 17'h0);
        step("jz0_ex1", 3'd4, 17'h0);
        bus.ZF = 1'b1;
        step("jz1_fa",  3'd1, FA);
        step("jz1_fi",  3'd2, FI);
        step("jz1_dec", 3'd3, 17'h0);
        step("jz1_ex1", 3'd4, W_PCL);
        bus.ZF = 1'b0;
        bus.CF = 1'b1;
        step("jc_fa",   3'd1, FA);
        chk("jz_target", {28'd0, pc}, 32'h4);
        step("jc_fi",   3'd2, FI);
        step("jc_dec",  3'd3, 17'h0);
        step("jc_ex1",  3'd4, W_PCL);
        bus.CF = 1'b0;
        step("padd_fa",  3'd1, FA);
        chk("jc_target", {28'd0, pc}, 32'h6);
        step("padd_fi",  3'd2, FI);
        step("padd_dec", 3'd3, 17'h0);
        step("padd_ex1", 3'd4, EA);
        bus.PRGM = 1'b1;
        step("padd_ex2", 3'd5, W_RRE | W_BWE);
        step("padd_ex3", 3'd6, W_AWE | W_FWE | W_ALU0);
        step("prog1",    3'd0, W_ACK);
        step("prog2",    3'd0, W_ACK);
        bus.PRGM = 1'b0;
        step("prog_idle", 3'd0, 17'h0);
        step("sta_fa",   3'd1, FA);
        step("sta_fi",   3'd2, FI);
        step("sta_dec",  3'd3, 17'h0);
        step("sta_ex1",  3'd4, EA);
        step("sta_ex2",  3'd5, W_AOE | W_RWE);
        RESET_N = 1'b0;
        step("sta_rst1", 3'd0, 17'h0);
        step("sta_rst2", 3'd0, 17'h0);

        // Opcode B as NOP, RUN=0 at boundary, LDA, then HALT -> PROGRAM
        mem[0] = 8'hB0; mem[1] = 8'h13; mem[2] = 8'hF0;
        pc = 4'h0;
        RESET_N = 1'b1;
        step("nop_fa",  3'd1, FA);
        step("nop_fi",  3'd2, FI);
        step("nop_dec", 3'd3, 17'h0);
        bus.RUN = 1'b0;
        step("nop_idle",  3'd0, 17'h0);
        step("idle_hold", 3'd0, 17'h0);
        bus.RUN = 1'b1;
        step("lda_fa",  3'd1, FA);
        step("lda_fi",  3'd2, FI);
        step("lda_dec", 3'd3, 17'h0);
        step("lda_ex1", 3'd4, EA);
        step("lda_ex2", 3'd5, W_RRE | W_AWE);
        step("h2_fa",   3'd1, FA);
        step("h2_fi",   3'd2, FI);
        step("h2_dec",  3'd3, 17'h0);
        step("h2_halt", 3'd7, W_HLT);
        bus.PRGM = 1'b1;
        step("halt_prog", 3'd0, W_ACK);
        bus.PRGM = 1'b0;
        step("halt_prog_idle", 3'd0, 17'h0);

        // Random opcode/flag run; bus drivers must stay mutually exclusive
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        rand_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            tick();
            chk("bus_onehot", {31'd0, $onehot0({bus.PC_OE, bus.ADDR_OE, bus.ACC_OE, bus.RAM_RE})}, 32'd1);
            if (bus.HALTED) begin
                RESET_N = 1'b0;
                tick();
                RESET_N = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
